bus_word_serializer: RTL and testbench

Receive-side counterpart of `bus_control`. Accepts a BUS_SIZE-bit bus together with its per-word control mask (one bit per WORD_SIZE-bit word, as driven on `data_out`/`control_out`). Emits only the flagged words, one per cycle, lowest index first, over a valid/ready handshake. Sits between the bus controller output and a narrow word-wide consumer.

---
 rtl/bus_word_serializer_pkg.sv | 13 +
 rtl/bus_word_serializer_if.sv | 28 ++
 rtl/bus_word_serializer_lowest_set_finder.sv | 25 ++
 rtl/bus_word_serializer.sv | 72 +++++++
 tb/tb_bus_word_serializer.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/bus_word_serializer_pkg.sv
// Shared defaults and state encoding for the bus controller and the word serializer.
package bus_word_serializer_pkg;

    localparam int BUS_SIZE  = 16;
    localparam int WORD_SIZE = 4;
    localparam int WORD_NUM  = BUS_SIZE / WORD_SIZE;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

endpackage

// File: rtl/bus_word_serializer_if.sv
// Bus-side input group plus word-side output channel of the serializer.
interface bus_word_serializer_if #(
    parameter int BUS_SIZE  = 16,
    parameter int WORD_SIZE = 4
);
    localparam int WORD_NUM = BUS_SIZE / WORD_SIZE;
    localparam int IDX_W    = (WORD_NUM > 1) ? $clog2(WORD_NUM) : 1;

    logic [BUS_SIZE-1:0]  data_in;
    logic [WORD_NUM-1:0]  control_in;
    logic                 in_valid;
    logic                 in_ready;
    logic [WORD_SIZE-1:0] word_out;
    logic [IDX_W-1:0]     word_idx;
    logic                 word_last;
    logic                 word_valid;
    logic                 word_ready;

    modport slave (
        input  data_in, control_in, in_valid, word_ready,
        output in_ready, word_out, word_idx, word_last, word_valid
    );

    modport master (
        output data_in, control_in, in_valid, word_ready,
        input  in_ready, word_out, word_idx, word_last, word_valid
    );
endinterface

// File: rtl/bus_word_serializer_lowest_set_finder.sv
// Priority encoder: index and one-hot of the lowest set bit of a mask.
module lowest_set_finder #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     mask,
    output logic [IDX_W-1:0] idx,
    output logic [N-1:0]     onehot,
    output logic             found
);
    always_comb begin
        idx    = '0;
        onehot = '0;
        found  = 1'b0;
        // Scan downward so the lowest set bit is the final writer.
        for (int i = N - 1; i >= 0; i--) begin
            if (mask[i]) begin
                idx    = IDX_W'(i);
                onehot = '0;
                onehot[i] = 1'b1;
                found  = 1'b1;
            end
        end
    end
endmodule

// File: rtl/bus_word_serializer.sv
// Emits the flagged words of an accepted bus one per cycle, lowest index first.
module bus_word_serializer
    import bus_word_serializer_pkg::*;
#(
    parameter int BUS_SIZE  = bus_word_serializer_pkg::BUS_SIZE,
    parameter int WORD_SIZE = bus_word_serializer_pkg::WORD_SIZE
) (
    input  logic                 clk,
    input  logic                 reset,
    bus_word_serializer_if.slave bus,
    output logic [7:0]           empty_cnt
);
    localparam int WORD_NUM = BUS_SIZE / WORD_SIZE;
    localparam int IDX_W    = (WORD_NUM > 1) ? $clog2(WORD_NUM) : 1;

    state_t                               state_q, state_d;
    logic [WORD_NUM-1:0][WORD_SIZE-1:0]   bus_q;
    logic [WORD_NUM-1:0]                  pend_q;
    logic [WORD_NUM-1:0]                  onehot;
    logic [IDX_W-1:0]                     idx;
    logic                                 found;
    logic                                 accept;
    logic                                 word_hs;
    logic                                 last;

    lowest_set_finder #(.N(WORD_NUM), .IDX_W(IDX_W)) u_finder (
        .mask   (pend_q),
        .idx    (idx),
        .onehot (onehot),
        .found  (found)
    );

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (accept)
            state_d = (bus.control_in != '0) ? SHIFT : IDLE;
        else if (word_hs && last)
            state_d = IDLE;
    end

    // Outputs depend only on state_q/bus_q/pend_q, never on data_in.
    always_comb begin
        bus.word_valid = (state_q == SHIFT);
        last           = bus.word_valid && found && (pend_q == onehot);
        bus.word_last  = last;
        bus.word_idx   = idx;
        bus.word_out   = bus_q[idx];
        word_hs        = bus.word_valid && bus.word_ready;
        bus.in_ready   = !reset && ((state_q == IDLE) || (word_hs && last));
        accept         = bus.in_valid && bus.in_ready;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bus_q     <= '0;
            pend_q    <= '0;
            empty_cnt <= '0;
        end else if (accept) begin
            bus_q  <= bus.data_in;
            pend_q <= bus.control_in;
            if (bus.control_in == '0 && empty_cnt != 8'hFF)
                empty_cnt <= empty_cnt + 8'd1;
        end else if (word_hs) begin
            pend_q <= pend_q & ~onehot;
        end
    end
endmodule

// File: tb/tb_bus_word_serializer.sv
// Vector table plus scoreboard bench for bus_word_serializer.
module tb_bus_word_serializer;

    typedef struct {
        logic [15:0] data;
        logic [3:0]  ctrl;
        int          n_words;
    } vec_t;

    typedef struct {
        logic [3:0] w;
        logic [1:0] idx;
        logic       last;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    logic [7:0] empty_cnt;
    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int word_cnt = 0;
    int acc_cyc = 0;
    exp_t sb[$];

    bus_word_serializer_if #(.BUS_SIZE(16), .WORD_SIZE(4)) bus ();

    bus_word_serializer dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .empty_cnt (empty_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: flagged words in ascending index, last = no higher flag.
    task automatic model_push(input logic [15:0] data, input logic [3:0] ctrl);
        exp_t e;
        for (int k = 0; k < 4; k++) begin
            if (ctrl[k]) begin
                e.w    = data[k*4 +: 4];
                e.idx  = 2'(k);
                e.last = ((ctrl >> (k + 1)) == 4'b0);
                sb.push_back(e);
            end
        end
    endtask

    always @(negedge clk) begin
        if (bus.word_valid && bus.word_ready) begin
            exp_t e;
            word_cnt++;
            if (sb.size() == 0) begin
                chk("unexpected_word", {28'b0, bus.word_out}, 32'hFFFF_FFFF);
            end else begin
                e = sb.pop_front();
                chk("sb_word", {28'b0, bus.word_out}, {28'b0, e.w});
                chk("sb_idx",  {30'b0, bus.word_idx}, {30'b0, e.idx});
                chk("sb_last", {31'b0, bus.word_last}, {31'b0, e.last});
            end
        end
    end

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send_bus(input logic [15:0] data, input logic [3:0] ctrl, input bit keep);
        bit ok = 0;
        bus.data_in    = data;
        bus.control_in = ctrl;
        bus.in_valid   = 1'b1;
        for (int n = 0; n < 64; n++) begin
            @(negedge clk);
            if (bus.in_ready) begin ok = 1; break; end
        end
        if (!ok) chk("accept_timeout", 0, 1);
        else model_push(data, ctrl);
        @(posedge clk);
        acc_cyc = cyc;
        #1;
        if (!keep) bus.in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok = 0;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (sb.size() == 0 && !bus.word_valid) begin ok = 1; break; end
        end
        if (!ok) chk("drain_timeout", 0, 1);
        @(posedge clk); #1;
    endtask

    vec_t vecs[7];
    int w0, acc1;

    initial begin
        vecs[0] = '{16'hA5C3, 4'b1010, 2};
        vecs[1] = '{16'h1234, 4'b1111, 4};
        vecs[2] = '{16'hBEEF, 4'b0001, 1};
        vecs[3] = '{16'h9876, 4'b0110, 2};
        vecs[4] = '{16'h0F0F, 4'b0000, 0};
        vecs[5] = '{16'hC001, 4'b1000, 1};
        vecs[6] = '{16'h5555, 4'b0101, 2};

        reset = 1'b1;
        bus.data_in = '0; bus.control_in = '0; bus.in_valid = 1'b0; bus.word_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        chk("rst_word_valid", {31'b0, bus.word_valid}, 0);
        chk("rst_word_out",   {28'b0, bus.word_out}, 0);
        chk("rst_word_idx",   {30'b0, bus.word_idx}, 0);
        chk("rst_word_last",  {31'b0, bus.word_last}, 0);
        chk("rst_empty_cnt",  {24'b0, empty_cnt}, 0);
        chk("rst_in_ready_forced", {31'b0, bus.in_ready}, 0);
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", {31'b0, bus.in_ready}, 1);
        chk("post_rst_word_valid", {31'b0, bus.word_valid}, 0);
        @(posedge clk); #1;

        foreach (vecs[i]) begin
            w0 = word_cnt;
            send_bus(vecs[i].data, vecs[i].ctrl, 0);
            @(negedge clk);
            chk("latency_valid", {31'b0, bus.word_valid}, {31'b0, vecs[i].ctrl != 4'b0});
            if (vecs[i].ctrl == 4'b0) chk("zero_mask_ready", {31'b0, bus.in_ready}, 1);
            wait_idle();
            chk("vec_word_count", word_cnt - w0, vecs[i].n_words);
        end

        // Back-to-back: second bus taken on the last word's handshake.
        send_bus(16'h1234, 4'b1111, 1);
        acc1 = acc_cyc;
        send_bus(16'hBEEF, 4'b0001, 0);
        chk("b2b_accept_gap", acc_cyc - acc1, 4);
        @(negedge clk);
        chk("b2b_no_bubble", {31'b0, bus.word_valid}, 1);
        chk("b2b_word", {28'b0, bus.word_out}, 32'hF);
        wait_idle();

        // Stall: outputs held while word_ready is low.
        bus.word_ready = 1'b0;
        send_bus(16'h9876, 4'b0110, 0);
        for (int s = 0; s < 3; s++) begin
            @(negedge clk);
            chk("stall_valid", {31'b0, bus.word_valid}, 1);
            chk("stall_word",  {28'b0, bus.word_out}, 32'h7);
            chk("stall_idx",   {30'b0, bus.word_idx}, 1);
            chk("stall_last",  {31'b0, bus.word_last}, 0);
            chk("stall_in_ready", {31'b0, bus.in_ready}, 0);
        end
        @(posedge clk); #1 bus.word_ready = 1'b1;
        wait_idle();

        // Reset while holding a partially drained bus.
        bus.word_ready = 1'b0;
        send_bus(16'h4321, 4'b1100, 0);
        @(negedge clk);
        chk("mid_idx_pending", {30'b0, bus.word_idx}, 2);
        @(posedge clk); #1 reset = 1'b1;
        @(negedge clk);
        chk("mid_in_ready_forced", {31'b0, bus.in_ready}, 0);
        @(posedge clk);
        @(negedge clk);
        chk("mid_rst_valid", {31'b0, bus.word_valid}, 0);
        sb.delete();
        @(posedge clk); #1 reset = 1'b0; bus.word_ready = 1'b1;
        w0 = word_cnt;
        repeat (5) @(negedge clk);
        chk("mid_rst_no_words", word_cnt - w0, 0);
        @(posedge clk); #1;

        // Empty-mask stream: counter saturates, nothing emitted.
        w0 = word_cnt;
        for (int i = 0; i < 300; i++) begin
            send_bus(16'($urandom), 4'b0000, i < 299);
            if (i == 253) chk("empty_cnt_254", {24'b0, empty_cnt}, 254);
            if (i == 254) chk("empty_cnt_255", {24'b0, empty_cnt}, 255);
        end
        @(negedge clk);
        chk("empty_cnt_sat", {24'b0, empty_cnt}, 255);
        chk("empty_no_words", word_cnt - w0, 0);
        chk("empty_in_ready", {31'b0, bus.in_ready}, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
